comp_stream: RTL and testbench

Parametrised, pipelined magnitude comparator with a valid/ready handshake, per-transaction signed/unsigned mode, and running statistics. Each accepted operand pair is compared and the gt/lt/eq result is registered. Saturating per-outcome counters and running min/max over all accepted operands are kept. The block sits between a producer and a consumer in the datapath and replaces the purely combinational comparator wherever flow control or accumulated statistics are required.

---
 rtl/comp_stream_if.sv | 38 +++
 rtl/comp_stream.sv | 128 ++++++++++++
 tb/tb_comp_stream.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/comp_stream_if.sv
// comp_stream_if: bundles the operand handshake, result handshake, statistics
// clear and statistics outputs of comp_stream.
//   master : producer/consumer side (drives operands, clear, out_ready)
//   slave  : comparator side (drives in_ready, result flags, statistics)
interface comp_stream_if #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned CNTWIDTH  = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic                 sgn;
    logic                 clear;
    logic                 out_valid;
    logic                 out_ready;
    logic                 gt;
    logic                 lt;
    logic                 eq;
    logic [DATAWIDTH-1:0] run_max;
    logic [DATAWIDTH-1:0] run_min;
    logic                 stats_valid;
    logic [CNTWIDTH-1:0]  gt_cnt;
    logic [CNTWIDTH-1:0]  lt_cnt;
    logic [CNTWIDTH-1:0]  eq_cnt;

    modport master (
        output in_valid, a, b, sgn, clear, out_ready,
        input  in_ready, out_valid, gt, lt, eq, run_max, run_min, stats_valid,
               gt_cnt, lt_cnt, eq_cnt
    );

    modport slave (
        input  in_valid, a, b, sgn, clear, out_ready,
        output in_ready, out_valid, gt, lt, eq, run_max, run_min, stats_valid,
               gt_cnt, lt_cnt, eq_cnt
    );
endinterface

// File: rtl/comp_stream.sv
// comp_stream: pipelined magnitude comparator with valid/ready flow control,
// per-pair signed/unsigned mode and running statistics (saturating outcome
// counters, running min/max).
//   Clk  : rising-edge clock
//   Rst  : synchronous active-high reset
//   bus  : comp_stream_if slave port (operands, result flags, statistics)
// All outputs are registered except bus.in_ready.
module comp_stream #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned CNTWIDTH  = 16
) (
    input logic          Clk,
    input logic          Rst,
    comp_stream_if.slave bus
);
    localparam logic [DATAWIDTH-1:0] MsbMask = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [CNTWIDTH-1:0]  CntMax  = '1;

    // Flipping the MSB maps two's complement order onto unsigned order.
    function automatic logic less(logic [DATAWIDTH-1:0] x, logic [DATAWIDTH-1:0] y,
                                  logic s);
        logic [DATAWIDTH-1:0] flip;
        flip = s ? MsbMask : '0;
        return (x ^ flip) < (y ^ flip);
    endfunction

    function automatic logic [CNTWIDTH-1:0] sat_inc(logic [CNTWIDTH-1:0] c);
        return (c == CntMax) ? c : c + CNTWIDTH'(1);
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic                 gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic [DATAWIDTH-1:0] max_q, max_d, min_q, min_d;
    logic                 stats_valid_q, stats_valid_d;
    logic [CNTWIDTH-1:0]  gt_cnt_q, gt_cnt_d, lt_cnt_q, lt_cnt_d, eq_cnt_q, eq_cnt_d;

    logic                 in_ready, accept;
    logic                 a_lt_b, b_lt_a, a_eq_b;
    logic [DATAWIDTH-1:0] hi, lo;
    logic                 base_valid;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        a_lt_b = less(bus.a, bus.b, bus.sgn);
        b_lt_a = less(bus.b, bus.a, bus.sgn);
        a_eq_b = (bus.a == bus.b);
        hi     = b_lt_a ? bus.a : bus.b;
        lo     = a_lt_b ? bus.a : bus.b;

        // clear is applied before a same-cycle accept.
        base_valid    = stats_valid_q && !bus.clear;
        max_d         = bus.clear ? '0 : max_q;
        min_d         = bus.clear ? '0 : min_q;
        stats_valid_d = base_valid;
        gt_cnt_d      = bus.clear ? '0 : gt_cnt_q;
        lt_cnt_d      = bus.clear ? '0 : lt_cnt_q;
        eq_cnt_d      = bus.clear ? '0 : eq_cnt_q;

        out_valid_d = out_valid_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;

        if (accept) begin
            out_valid_d   = 1'b1;
            gt_d          = b_lt_a;
            lt_d          = a_lt_b;
            eq_d          = a_eq_b;
            stats_valid_d = 1'b1;
            if (!base_valid) begin
                max_d = hi;
                min_d = lo;
            end else begin
                // Stored extremes are reinterpreted under this pair's sgn.
                if (less(max_d, hi, bus.sgn)) max_d = hi;
                if (less(lo, min_d, bus.sgn)) min_d = lo;
            end
            if (b_lt_a) gt_cnt_d = sat_inc(gt_cnt_d);
            if (a_lt_b) lt_cnt_d = sat_inc(lt_cnt_d);
            if (a_eq_b) eq_cnt_d = sat_inc(eq_cnt_d);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            gt_d        = 1'b0;
            lt_d        = 1'b0;
            eq_d        = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid_q   <= 1'b0;
            gt_q          <= 1'b0;
            lt_q          <= 1'b0;
            eq_q          <= 1'b0;
            max_q         <= '0;
            min_q         <= '0;
            stats_valid_q <= 1'b0;
            gt_cnt_q      <= '0;
            lt_cnt_q      <= '0;
            eq_cnt_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            gt_q          <= gt_d;
            lt_q          <= lt_d;
            eq_q          <= eq_d;
            max_q         <= max_d;
            min_q         <= min_d;
            stats_valid_q <= stats_valid_d;
            gt_cnt_q      <= gt_cnt_d;
            lt_cnt_q      <= lt_cnt_d;
            eq_cnt_q      <= eq_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.gt          = gt_q;
    assign bus.lt          = lt_q;
    assign bus.eq          = eq_q;
    assign bus.run_max     = max_q;
    assign bus.run_min     = min_q;
    assign bus.stats_valid = stats_valid_q;
    assign bus.gt_cnt      = gt_cnt_q;
    assign bus.lt_cnt      = lt_cnt_q;
    assign bus.eq_cnt      = eq_cnt_q;
endmodule

// File: tb/tb_comp_stream.sv
// tb_comp_stream: directed and randomized stimulus for comp_stream
// (DATAWIDTH=8, CNTWIDTH=2) checked against an integer-arithmetic model.
module tb_comp_stream;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;
    localparam int          CntSat = (1 << CW) - 1;

    logic Clk;
    logic Rst;

    comp_stream_if #(.DATAWIDTH(DW), .CNTWIDTH(CW)) bus ();

    comp_stream #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests;
    int fails;

    // Reference model state.
    bit       m_ov, m_gt, m_lt, m_eq, m_sv;
    bit [7:0] m_max, m_min;
    int       m_gtc, m_ltc, m_eqc;

    function automatic int val(logic [7:0] x, logic s);
        int r;
        if (s) r = {{24{x[7]}}, x};
        else   r = {24'b0, x};
        return r;
    endfunction

    function automatic int inc_sat(int c);
        return (c >= CntSat) ? c : c + 1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("gt", 32'(bus.gt), 32'(m_gt));
        check("lt", 32'(bus.lt), 32'(m_lt));
        check("eq", 32'(bus.eq), 32'(m_eq));
        check("stats_valid", 32'(bus.stats_valid), 32'(m_sv));
        check("run_max", 32'(bus.run_max), 32'(m_max));
        check("run_min", 32'(bus.run_min), 32'(m_min));
        check("gt_cnt", 32'(bus.gt_cnt), m_gtc);
        check("lt_cnt", 32'(bus.lt_cnt), m_ltc);
        check("eq_cnt", 32'(bus.eq_cnt), m_eqc);
    endtask

    // One clock: check in_ready, predict the edge, then check all outputs.
    task automatic tick();
        bit acc;
        int va, vb;
        bit [7:0] hi, lo;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(!m_ov || bus.out_ready));
        acc = !Rst && bus.in_valid && (!m_ov || bus.out_ready);
        @(posedge Clk);
        if (Rst) begin
            m_ov = 0; m_gt = 0; m_lt = 0; m_eq = 0; m_sv = 0;
            m_max = 0; m_min = 0; m_gtc = 0; m_ltc = 0; m_eqc = 0;
        end else begin
            if (bus.clear) begin
                m_sv = 0; m_max = 0; m_min = 0; m_gtc = 0; m_ltc = 0; m_eqc = 0;
            end
            if (acc) begin
                va = val(bus.a, bus.sgn);
                vb = val(bus.b, bus.sgn);
                m_gt = va > vb; m_lt = va < vb; m_eq = va == vb;
                hi = (va >= vb) ? bus.a : bus.b;
                lo = (va <= vb) ? bus.a : bus.b;
                if (!m_sv) begin
                    m_max = hi; m_min = lo;
                end else begin
                    if (val(hi, bus.sgn) > val(m_max, bus.sgn)) m_max = hi;
                    if (val(lo, bus.sgn) < val(m_min, bus.sgn)) m_min = lo;
                end
                m_sv = 1;
                if (m_gt) m_gtc = inc_sat(m_gtc);
                if (m_lt) m_ltc = inc_sat(m_ltc);
                if (m_eq) m_eqc = inc_sat(m_eqc);
                m_ov = 1;
            end else if (m_ov && bus.out_ready) begin
                m_ov = 0; m_gt = 0; m_lt = 0; m_eq = 0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(bit v, bit [7:0] av, bit [7:0] bv, bit s, bit clr, bit ordy);
        bus.in_valid  = v;
        bus.a         = av;
        bus.b         = bv;
        bus.sgn       = s;
        bus.clear     = clr;
        bus.out_ready = ordy;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_ov = 0; m_gt = 0; m_lt = 0; m_eq = 0; m_sv = 0;
        m_max = 0; m_min = 0; m_gtc = 0; m_ltc = 0; m_eqc = 0;

        // Reset held two cycles with in_valid asserted.
        Rst = 1'b1;
        drive(1, 8'd5, 8'd3, 0, 0, 1);
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_gt_cnt", 32'(bus.gt_cnt), 32'd0);
        Rst = 1'b0;
        drive(0, 8'd0, 8'd0, 0, 0, 1);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Unsigned back-to-back.
        drive(1, 8'd20, 8'd15, 0, 0, 1); tick();
        check("u_gt", 32'({bus.gt, bus.lt, bus.eq}), 32'b100);
        drive(1, 8'd6, 8'd10, 0, 0, 1); tick();
        check("u_lt", 32'({bus.gt, bus.lt, bus.eq}), 32'b010);
        drive(1, 8'd9, 8'd9, 0, 0, 1); tick();
        check("u_eq", 32'({bus.gt, bus.lt, bus.eq}), 32'b001);
        check("u_cnts", 32'({bus.gt_cnt, bus.lt_cnt, bus.eq_cnt}), 32'b010101);
        check("u_max", 32'(bus.run_max), 32'd20);
        check("u_min", 32'(bus.run_min), 32'd6);

        // Signed versus unsigned on the same pair.
        drive(1, 8'hFA, 8'h0A, 1, 0, 1); tick();
        check("s_lt", 32'(bus.lt), 32'd1);
        drive(1, 8'hFA, 8'h0A, 0, 0, 1); tick();
        check("us_gt", 32'(bus.gt), 32'd1);
        drive(0, 8'h00, 8'h00, 0, 1, 1); tick();
        check("clr_sv", 32'(bus.stats_valid), 32'd0);
        drive(1, 8'h80, 8'h7F, 1, 0, 1); tick();
        check("s_min", 32'(bus.run_min), 32'h80);
        check("s_max", 32'(bus.run_max), 32'h7F);

        // Backpressure.
        drive(1, 8'd1, 8'd2, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'd5, 8'd3, 0, 0, 0); tick();
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_lt_hold", 32'(bus.lt), 32'd1);
        end
        drive(1, 8'd5, 8'd3, 0, 0, 1); tick();
        check("bp_release_gt", 32'({bus.out_valid, bus.gt}), 32'b11);

        // Saturation with CNTWIDTH=2.
        drive(0, 8'd0, 8'd0, 0, 1, 1); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'd42, 8'd42, 0, 0, 1); tick();
        end
        check("sat_eq", 32'(bus.eq_cnt), 32'd3);
        drive(1, 8'd42, 8'd42, 0, 0, 1); tick();
        check("sat_eq_hold", 32'(bus.eq_cnt), 32'd3);
        check("sat_others", 32'({bus.gt_cnt, bus.lt_cnt}), 32'd0);

        // Clear together with an accept.
        drive(1, 8'd200, 8'd1, 0, 0, 1); tick();
        drive(1, 8'd0, 8'd99, 0, 0, 1); tick();
        drive(1, 8'd3, 8'd7, 0, 1, 1); tick();
        check("ca_cnts", 32'({bus.gt_cnt, bus.lt_cnt, bus.eq_cnt}), 32'b000100);
        check("ca_max", 32'(bus.run_max), 32'd7);
        check("ca_min", 32'(bus.run_min), 32'd3);
        check("ca_sv", 32'(bus.stats_valid), 32'd1);

        // Reset drops a pending unconsumed result.
        drive(1, 8'd4, 8'd4, 0, 0, 0); tick();
        Rst = 1'b1; tick();
        Rst = 1'b0;
        check("rst_drop", 32'(bus.out_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 8'h80;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            Rst = ($urandom_range(0, 63) == 0);
            drive(bit'($urandom_range(0, 3) != 0), ra, rb, bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), bit'($urandom_range(0, 2) != 0));
            tick();
        end
        Rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
